// File: rtl/vending_token_tx_if.sv
// Coin-request handshake plus machine-side token/accept/dispense lines for vending_token_tx.
// The slave modport is the transmitter; the master modport is the coin front end / machine.
interface vending_token_tx_if #(
  parameter int unsigned CNT_W = 8
);
  logic             coin_valid;
  logic [1:0]       coin_type;
  logic             coin_ready;
  logic             a_in;
  logic             p_in;
  logic             t_out;
  logic             busy;
  logic             frame_done;
  logic             tmo_err;
  logic             ill_err;
  logic [CNT_W-1:0] coin_cnt;
  logic [CNT_W-1:0] prod_cnt;

  modport master (
    output coin_valid, coin_type, a_in, p_in,
    input  coin_ready, t_out, busy, frame_done, tmo_err, ill_err, coin_cnt, prod_cnt
  );

  modport slave (
    input  coin_valid, coin_type, a_in, p_in,
    output coin_ready, t_out, busy, frame_done, tmo_err, ill_err, coin_cnt, prod_cnt
  );
endinterface

// File: rtl/vending_token_tx.sv
// Serialises coin requests as pulse bursts on the token line and waits for the machine's accept.
// Optional VEND_TX_GAP_EN inserts GAP_CYC idle cycles after every frame before accepting again.
module vending_token_tx #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ACK_TMO = 16,
  parameter int unsigned GAP_CYC = 2
) (
  input logic                clk,
  input logic                rst_n,
  vending_token_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StStop,
`ifdef VEND_TX_GAP_EN
    StGap,
`endif
    StWaitAck
  } state_e;

  localparam logic [7:0] TmoLast = 8'(ACK_TMO - 1);

`ifdef VEND_TX_GAP_EN
  localparam int unsigned GapW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);
  localparam state_e ExitSt = StGap;
`else
  localparam state_e ExitSt = StIdle;
`endif

  state_e           state_q, state_d;
  logic [1:0]       burst_q, burst_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             t_out_q, t_out_d;
  logic             frame_done_q, frame_done_d;
  logic             ill_err_q, ill_err_d;
  logic             tmo_err_q, tmo_err_d;
  logic [CNT_W-1:0] coin_cnt_q, coin_cnt_d;
  logic [CNT_W-1:0] prod_cnt_q, prod_cnt_d;
`ifdef VEND_TX_GAP_EN
  logic [GapW-1:0]  gap_q, gap_d;
`else
  logic             unused_gap_cyc;
  assign unused_gap_cyc = ^GAP_CYC;
`endif

  logic busy;
  logic coin_ready;
  logic handshake;

  // Ready is held low during reset even though the state register already reads idle.
  assign busy       = (state_q != StIdle);
  assign coin_ready = rst_n & (state_q == StIdle);
  assign handshake  = bus.coin_valid & coin_ready;

  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    tmo_d        = tmo_q;
    t_out_d      = 1'b0;
    frame_done_d = 1'b0;
    ill_err_d    = 1'b0;
    tmo_err_d    = tmo_err_q;
    coin_cnt_d   = coin_cnt_q;
    prod_cnt_d   = prod_cnt_q;
`ifdef VEND_TX_GAP_EN
    gap_d        = gap_q;
`endif

    if (busy && bus.p_in && (prod_cnt_q != '1)) begin
      prod_cnt_d = prod_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          if (bus.coin_type == 2'd3) begin
            ill_err_d = 1'b1;
          end else begin
            state_d = StSend;
            t_out_d = 1'b1;
            burst_d = bus.coin_type;  // pulses still owed after the first one
          end
        end
      end
      StSend: begin
        if (burst_q == 2'd0) begin
          state_d = StStop;
        end else begin
          burst_d = burst_q - 2'd1;
          t_out_d = 1'b1;
        end
      end
      StStop: begin
        state_d = StWaitAck;
        tmo_d   = '0;
      end
      StWaitAck: begin
        if (bus.a_in) begin
          frame_done_d = 1'b1;
          if (coin_cnt_q != '1) begin
            coin_cnt_d = coin_cnt_q + CNT_W'(1);
          end
          state_d = ExitSt;
        end else if (tmo_q == TmoLast) begin
          tmo_err_d = 1'b1;
          state_d   = ExitSt;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`ifdef VEND_TX_GAP_EN
        gap_d = '0;
`endif
      end
`ifdef VEND_TX_GAP_EN
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      burst_q      <= '0;
      tmo_q        <= '0;
      t_out_q      <= 1'b0;
      frame_done_q <= 1'b0;
      ill_err_q    <= 1'b0;
      tmo_err_q    <= 1'b0;
      coin_cnt_q   <= '0;
      prod_cnt_q   <= '0;
`ifdef VEND_TX_GAP_EN
      gap_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      tmo_q        <= tmo_d;
      t_out_q      <= t_out_d;
      frame_done_q <= frame_done_d;
      ill_err_q    <= ill_err_d;
      tmo_err_q    <= tmo_err_d;
      coin_cnt_q   <= coin_cnt_d;
      prod_cnt_q   <= prod_cnt_d;
`ifdef VEND_TX_GAP_EN
      gap_q        <= gap_d;
`endif
    end
  end

  assign bus.coin_ready = coin_ready;
  assign bus.busy       = busy;
  assign bus.t_out      = t_out_q;
  assign bus.frame_done = frame_done_q;
  assign bus.ill_err    = ill_err_q;
  assign bus.tmo_err    = tmo_err_q;
  assign bus.coin_cnt   = coin_cnt_q;
  assign bus.prod_cnt   = prod_cnt_q;

endmodule

// File: tb/tb_vending_token_tx.sv
// Scoreboard bench for vending_token_tx: drivers push expected line events, a negedge monitor
// pops and compares them; register-level values are checked directly at fixed points.
module tb_vending_token_tx;

  localparam int unsigned CntW   = 8;
  localparam int unsigned AckTmo = 16;
`ifdef VEND_TX_GAP_EN
  localparam int GapCyc = 2;
`else
  localparam int GapCyc = 0;
`endif

  localparam int EvT    = 0;
  localparam int EvDone = 1;
  localparam int EvTmo  = 2;
  localparam int EvIll  = 3;

  localparam int EndNone = 0;
  localparam int EndDone = 1;
  localparam int EndTmo  = 2;

  typedef struct {
    int kind;
    int cyc;
    int len;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];

  vending_token_tx_if #(.CNT_W(CntW)) bus ();

  vending_token_tx #(
    .CNT_W  (CntW),
    .ACK_TMO(AckTmo),
    .GAP_CYC(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at, input int len);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int at, input int len);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_eq($sformatf("spurious_ev%0d", kind), kind, 32'hffff_ffff);
      return;
    end
    e = exp_q.pop_front();
    check_eq("ev_kind", kind, e.kind);
    check_eq($sformatf("ev%0d_cycle", e.kind), at, e.cyc);
    check_eq($sformatf("ev%0d_len", e.kind), len, e.len);
  endtask

  // Monitor: turns line activity into events for the scoreboard.
  logic t_prev = 1'b0;
  logic tmo_prev = 1'b0;
  int   t_start = 0;
  int   t_len_r = 0;

  always @(negedge clk) begin
    if (bus.t_out === 1'b1) begin
      if (!t_prev) begin
        t_start <= cyc;
        t_len_r <= 1;
      end else begin
        t_len_r <= t_len_r + 1;
      end
    end else if (t_prev) begin
      observe(EvT, t_start, t_len_r);
    end
    t_prev <= (bus.t_out === 1'b1);
    if (bus.frame_done === 1'b1) observe(EvDone, cyc, 0);
    if (bus.ill_err === 1'b1) observe(EvIll, cyc, 0);
    if (bus.tmo_err === 1'b1 && !tmo_prev) observe(EvTmo, cyc, 0);
    tmo_prev <= (bus.tmo_err === 1'b1);
  end

  // Handshake one coin; n is the cycle whose closing edge performs the transfer.
  task automatic send_coin(input logic [1:0] ty, input int t_len, input int end_kind,
                           output int n);
    int guard = 0;
    @(negedge clk);
    bus.coin_valid = 1'b1;
    bus.coin_type  = ty;
    while (bus.coin_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check_eq("ready_wait", 32'(bus.coin_ready), 1);
    n = cyc;
    if (ty == 2'd3) begin
      push_ev(EvIll, n + 1, 0);
    end else begin
      push_ev(EvT, n + 1, t_len);
      if (end_kind == EndDone) push_ev(EvDone, n + int'(ty) + 4, 0);
      if (end_kind == EndTmo) push_ev(EvTmo, n + int'(ty) + 3 + int'(AckTmo), 0);
    end
    @(posedge clk);
    #1 bus.coin_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check_eq({"drain_", tag}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int r;
    int guard;

    rst_n          = 1'b0;
    bus.coin_valid = 1'b1;
    bus.coin_type  = 2'd0;
    bus.a_in       = 1'b1;
    bus.p_in       = 1'b0;

    // Reset held with a pending coin request
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_t_out", 32'(bus.t_out), 0);
    check_eq("rst_coin_ready", 32'(bus.coin_ready), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_coin_cnt", 32'(bus.coin_cnt), 0);
    check_eq("rst_prod_cnt", 32'(bus.prod_cnt), 0);
    check_eq("rst_tmo_err", 32'(bus.tmo_err), 0);
    bus.coin_valid = 1'b0;
    rst_n          = 1'b1;

    // Type 2 acknowledged at once, dispense held high throughout
    bus.p_in = 1'b1;
    send_coin(2'd2, 3, EndDone, n);
    guard = 0;
    @(negedge clk);
    while (bus.coin_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    r = cyc;
    check_eq("ready_return", r, n + 6 + GapCyc);
    check_eq("t2_coin_cnt", 32'(bus.coin_cnt), 1);
    check_eq("t2_prod_cnt", 32'(bus.prod_cnt), 5 + GapCyc);
    check_eq("t2_busy", 32'(bus.busy), 0);
    bus.p_in = 1'b0;
    drain("t2");

    // Illegal coin type
    send_coin(2'd3, 0, EndNone, n);
    @(negedge clk);
    check_eq("ill_coin_ready", 32'(bus.coin_ready), 1);
    check_eq("ill_busy", 32'(bus.busy), 0);
    check_eq("ill_t_out", 32'(bus.t_out), 0);
    drain("ill");

    // Timeout with accept held low
    bus.a_in = 1'b0;
    send_coin(2'd0, 1, EndTmo, n);
    drain("tmo");
    repeat (GapCyc + 2) @(negedge clk);
    check_eq("tmo_sticky", 32'(bus.tmo_err), 1);
    check_eq("tmo_coin_cnt", 32'(bus.coin_cnt), 1);
    check_eq("tmo_busy", 32'(bus.busy), 0);
    bus.a_in = 1'b1;

    // Reset in the middle of a type 2 burst
    send_coin(2'd2, 1, EndNone, n);
    @(negedge clk);
    check_eq("abort_t_high", 32'(bus.t_out), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_t_out", 32'(bus.t_out), 0);
    check_eq("abort_busy", 32'(bus.busy), 0);
    check_eq("abort_ready_in_rst", 32'(bus.coin_ready), 0);
    check_eq("abort_coin_cnt", 32'(bus.coin_cnt), 0);
    check_eq("abort_prod_cnt", 32'(bus.prod_cnt), 0);
    check_eq("abort_tmo_err", 32'(bus.tmo_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_ready_after", 32'(bus.coin_ready), 1);
    drain("abort");

    // Back-to-back frames drive both counters into saturation
    bus.p_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_coin(2'd0, 1, EndDone, n);
    end
    drain("sat");
    repeat (GapCyc + 2) @(negedge clk);
    check_eq("sat_coin_cnt", 32'(bus.coin_cnt), 255);
    check_eq("sat_prod_cnt", 32'(bus.prod_cnt), 255);
    bus.p_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
